fetch_queue: RTL and testbench

- Instruction prefetch buffer between the instruction memory and the instruction register.
- Drives the instruction-memory read address and captures returned words into a small circular FIFO, tagging each word with its fetch address.
- Presents the oldest instruction to the IR load path.
- On a taken branch, the control unit flushes the queue and redirects fetch to the branch target.

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches words from instruction memory into a
// circular buffer tagged with their fetch address; flushable on branches.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_data,
    input  logic          fetch_en,
    input  logic          deq,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic [DW-1:0] head_instr,
    output logic [AW-1:0] head_pc,
    output logic          valid,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [AW-1:0] fpc_q, fpc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] instr_q [DEPTH];
    logic [AW-1:0] pc_q [DEPTH];
    logic          enq;
    logic          deq_eff;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign im_addr = fpc_q;

    assign deq_eff = deq & valid & ~flush;
    // A full queue can still accept a word when the head leaves this cycle.
    assign enq     = fetch_en & ~flush & (~full | deq_eff);

    assign head_instr = valid ? instr_q[rd_ptr_q] : '0;
    assign head_pc    = valid ? pc_q[rd_ptr_q] : '0;

    always_comb begin
        fpc_d    = fpc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            fpc_d    = flush_addr;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (enq) begin
                fpc_d    = fpc_q + AW'(1);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq_eff) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            fpc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; reads are gated by valid.
    always_ff @(posedge clk) begin
        if (!rst_f && enq) begin
            instr_q[wr_ptr_q] <= im_data;
            pc_q[wr_ptr_q]    <= fpc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic          clk = 0;
    logic          rst_f = 1;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_data;
    logic          fetch_en = 0;
    logic          deq = 0;
    logic          flush = 0;
    logic [AW-1:0] flush_addr = '0;
    logic [DW-1:0] head_instr;
    logic [AW-1:0] head_pc;
    logic          valid;
    logic          full;
    logic [2:0]    count;

    int passed = 0;
    int total  = 0;

    logic [DW+AW-1:0] mq[$];
    logic [AW-1:0]    mfpc = '0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + {16'h0, a};
    endfunction

    assign im_data = mem_word(im_addr);

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_f(rst_f), .im_addr(im_addr), .im_data(im_data),
        .fetch_en(fetch_en), .deq(deq), .flush(flush),
        .flush_addr(flush_addr), .head_instr(head_instr),
        .head_pc(head_pc), .valid(valid), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit de, en;
        if (rst_f) begin
            mq.delete();
            mfpc = '0;
        end else if (flush) begin
            mq.delete();
            mfpc = flush_addr;
        end else begin
            de = deq && (mq.size() > 0);
            en = fetch_en && (mq.size() < DEPTH || de);
            if (de) void'(mq.pop_front());
            if (en) begin
                mq.push_back({mem_word(mfpc), mfpc});
                mfpc = mfpc + 16'd1;
            end
        end
    endtask

    task automatic check_model();
        logic [DW-1:0] ei;
        logic [AW-1:0] ep;
        ei = '0;
        ep = '0;
        if (mq.size() > 0) {ei, ep} = mq[0];
        cmp("count", 32'(count), 32'(mq.size()));
        cmp("valid", 32'(valid), 32'(mq.size() > 0));
        cmp("full", 32'(full), 32'(mq.size() == DEPTH));
        cmp("head_instr", head_instr, ei);
        cmp("head_pc", 32'(head_pc), 32'(ep));
        cmp("im_addr", 32'(im_addr), 32'(mfpc));
    endtask

    task automatic step(input bit r, input bit fe, input bit d,
                        input bit fl, input logic [AW-1:0] fa);
        rst_f = r; fetch_en = fe; deq = d; flush = fl; flush_addr = fa;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 16'h1234);
        cmp("rst_count", 32'(count), 0);
        cmp("rst_im_addr", 32'(im_addr), 0);
        cmp("rst_valid", 32'(valid), 0);

        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        cmp("fill_count", 32'(count), 4);
        cmp("fill_full", 32'(full), 1);
        cmp("fill_im_addr", 32'(im_addr), 4);
        cmp("fill_head_pc", 32'(head_pc), 0);
        cmp("fill_head_instr", head_instr, 32'h1000_0000);

        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 0, 0);
            cmp("stream_head_pc", 32'(head_pc), 32'(i));
            cmp("stream_count", 32'(count), 4);
        end

        step(0, 0, 1, 0, 0);
        cmp("pre_flush_count", 32'(count), 3);
        step(0, 1, 1, 1, 16'h0040);
        cmp("flush_valid", 32'(valid), 0);
        cmp("flush_count", 32'(count), 0);
        cmp("flush_im_addr", 32'(im_addr), 32'h40);
        step(0, 1, 0, 0, 0);
        cmp("flush_head_pc", 32'(head_pc), 32'h40);
        cmp("flush_head_instr", head_instr, 32'h1000_0040);
        cmp("flush_count1", 32'(count), 1);

        step(0, 0, 0, 1, 16'h0080);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            cmp("uflow_count", 32'(count), 0);
            cmp("uflow_head_instr", head_instr, 0);
        end
        step(0, 1, 0, 0, 0);
        cmp("uflow_head_pc", 32'(head_pc), 32'h80);
        cmp("uflow_count1", 32'(count), 1);

        step(0, 1, 1, 1, 16'hFFFE);
        step(0, 1, 1, 0, 0);
        cmp("wrap_pc0", 32'(head_pc), 32'hFFFE);
        step(0, 1, 1, 0, 0);
        cmp("wrap_pc1", 32'(head_pc), 32'hFFFF);
        step(0, 1, 1, 0, 0);
        cmp("wrap_pc2", 32'(head_pc), 32'h0000);
        cmp("wrap_instr2", head_instr, 32'h1000_0000);
        step(0, 1, 1, 0, 0);
        cmp("wrap_pc3", 32'(head_pc), 32'h0001);

        step(0, 0, 0, 1, 16'h0010);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        cmp("mid_count", 32'(count), 2);
        step(1, 1, 1, 1, 16'h0055);
        cmp("mid_rst_count", 32'(count), 0);
        cmp("mid_rst_im_addr", 32'(im_addr), 0);
        cmp("mid_rst_valid", 32'(valid), 0);
        step(0, 1, 0, 0, 0);
        cmp("restart_head_pc", 32'(head_pc), 0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0),
                 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
